// File: rtl/seq_cntrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/WRITE_BACK with halt/resume and an execute-timeout trap.
// Defining SEQ_PERF_CNT_EN adds the retired and stall_cycles performance counters.
module seq_cntrl #(
  parameter int          WIDTH        = 32,
  parameter logic [4:0]  HALT_OPC     = 5'h1F,
  parameter int          EXEC_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_inst,
  output logic [WIDTH-1:0] ir,
  output logic             ex_start,
  input  logic             ex_done,
  input  logic             wb_suppress,
  output logic             rf_write_en,
  output logic             pc_enable,
  output logic [2:0]       state,
  output logic             halted,
  output logic             exec_err
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]      retired,
  output logic [31:0]      stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_DECODE     = 3'd2,
    S_EXECUTE    = 3'd3,
    S_WRITE_BACK = 3'd4,
    S_HALT       = 3'd5,
    S_ERROR      = 3'd6
  } state_t;

  localparam int                CNT_W       = (EXEC_TIMEOUT < 2) ? 1 : $clog2(EXEC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(EXEC_TIMEOUT);

  state_t           cur;
  logic             run_q;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             halt_exit;
  logic             timeout_hit;

  assign cnt_next    = exec_cnt + CNT_W'(1);
  assign halt_exit   = (cur == S_HALT) && run && !run_q;
  // ex_done in the timeout cycle takes priority, so the timeout only fires without it.
  assign timeout_hit = (EXEC_TIMEOUT != 0) && !ex_done && (cnt_next == TIMEOUT_CNT);

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur      <= S_IDLE;
      ir       <= '0;
      exec_cnt <= '0;
      run_q    <= 1'b0;
      ex_start <= 1'b0;
    end else begin
      run_q    <= run;
      ex_start <= 1'b0;
      case (cur)
        S_IDLE: if (run) cur <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            ir  <= imem_inst;
            cur <= S_DECODE;
          end
        end
        S_DECODE: begin
          exec_cnt <= '0;
          if (ir[WIDTH-1:WIDTH-5] == HALT_OPC) begin
            cur <= S_HALT;
          end else begin
            cur      <= S_EXECUTE;
            ex_start <= 1'b1;
          end
        end
        S_EXECUTE: begin
          exec_cnt <= cnt_next;
          if (ex_done)          cur <= S_WRITE_BACK;
          else if (timeout_hit) cur <= S_ERROR;
        end
        S_WRITE_BACK: cur <= run ? S_FETCH : S_IDLE;
        S_HALT:       if (halt_exit) cur <= S_FETCH;
        S_ERROR:      cur <= S_ERROR;
        default:      cur <= S_IDLE;
      endcase
    end
  end

  assign state       = cur;
  assign imem_req    = (cur == S_FETCH);
  assign rf_write_en = (cur == S_WRITE_BACK) && !wb_suppress;
  assign pc_enable   = (cur == S_WRITE_BACK) || halt_exit;
  assign halted      = (cur == S_HALT);
  assign exec_err    = (cur == S_ERROR);

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired      <= '0;
      stall_cycles <= '0;
    end else begin
      if ((cur == S_WRITE_BACK) || halt_exit)
        retired <= retired + 32'd1;
      if (((cur == S_FETCH) && !imem_ready) || ((cur == S_EXECUTE) && !ex_done))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_cntrl.sv
// Directed bench for seq_cntrl: per-cycle vector table plus hand-written reset sequences.
module tb_seq_cntrl;

  logic        clk;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_inst;
  logic [31:0] ir;
  logic        ex_start;
  logic        ex_done;
  logic        wb_suppress;
  logic        rf_write_en;
  logic        pc_enable;
  logic [2:0]  state;
  logic        halted;
  logic        exec_err;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired;
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  seq_cntrl #(.WIDTH(32), .HALT_OPC(5'h1F), .EXEC_TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .imem_inst   (imem_inst),
    .ir          (ir),
    .ex_start    (ex_start),
    .ex_done     (ex_done),
    .wb_suppress (wb_suppress),
    .rf_write_en (rf_write_en),
    .pc_enable   (pc_enable),
    .state       (state),
    .halted      (halted),
    .exec_err    (exec_err)
`ifdef SEQ_PERF_CNT_EN
    ,
    .retired     (retired),
    .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic        rdy;
    logic [31:0] inst;
    logic        done;
    logic        sup;
    logic [2:0]  st;
    logic        req;
    logic        exs;
    logic        we;
    logic        pce;
    logic        hlt;
    logic        err;
    logic [31:0] ir;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rd, input logic [31:0] in, input logic d, input logic s,
                     input logic [2:0] st, input logic rq, input logic es, input logic we,
                     input logic pe, input logic h, input logic e, input logic [31:0] irv);
    vec_t v;
    v = '{run: r, rdy: rd, inst: in, done: d, sup: s, st: st, req: rq, exs: es,
          we: we, pce: pe, hlt: h, err: e, ir: irv};
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] st, input logic rq, input logic es,
                               input logic we, input logic pe, input logic h, input logic e,
                               input logic [31:0] irv);
    check({tag, " state"},       32'(state),       32'(st));
    check({tag, " imem_req"},    32'(imem_req),    32'(rq));
    check({tag, " ex_start"},    32'(ex_start),    32'(es));
    check({tag, " rf_write_en"}, 32'(rf_write_en), 32'(we));
    check({tag, " pc_enable"},   32'(pc_enable),   32'(pe));
    check({tag, " halted"},      32'(halted),      32'(h));
    check({tag, " exec_err"},    32'(exec_err),    32'(e));
    check({tag, " ir"},          ir,               irv);
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; imem_ready = 1'b0; imem_inst = '0; ex_done = 1'b0; wb_suppress = 1'b0;

    //   run rdy inst           done sup | st req exs we pce hlt err ir
    add(0, 1, 32'h0000_0000, 1, 0,   0, 0, 0, 0, 0, 0, 0, 32'h0000_0000); // c0  idle
    add(1, 1, 32'h0000_0000, 1, 0,   0, 0, 0, 0, 0, 0, 0, 32'h0000_0000); // c1  idle -> fetch
    add(1, 1, 32'h0000_0000, 1, 0,   1, 1, 0, 0, 0, 0, 0, 32'h0000_0000); // c2  fetch
    add(1, 1, 32'h0000_0000, 1, 0,   2, 0, 0, 0, 0, 0, 0, 32'h0000_0000); // c3  decode
    add(1, 1, 32'h0000_0000, 1, 0,   3, 0, 1, 0, 0, 0, 0, 32'h0000_0000); // c4  execute, done at once
    add(1, 1, 32'h0000_0000, 1, 0,   4, 0, 0, 1, 1, 0, 0, 32'h0000_0000); // c5  write back
    add(1, 1, 32'h1234_5678, 1, 0,   1, 1, 0, 0, 0, 0, 0, 32'h0000_0000); // c6  back-to-back fetch
    add(1, 1, 32'h1234_5678, 1, 0,   2, 0, 0, 0, 0, 0, 0, 32'h1234_5678); // c7
    add(1, 1, 32'h1234_5678, 1, 0,   3, 0, 1, 0, 0, 0, 0, 32'h1234_5678); // c8
    add(1, 1, 32'h1234_5678, 1, 1,   4, 0, 0, 0, 1, 0, 0, 32'h1234_5678); // c9  suppressed write
    add(1, 0, 32'hDEAD_BEEF, 1, 0,   1, 1, 0, 0, 0, 0, 0, 32'h1234_5678); // c10 fetch stall 1
    add(1, 0, 32'hDEAD_BEEF, 1, 0,   1, 1, 0, 0, 0, 0, 0, 32'h1234_5678); // c11 fetch stall 2
    add(1, 0, 32'hDEAD_BEEF, 1, 0,   1, 1, 0, 0, 0, 0, 0, 32'h1234_5678); // c12 fetch stall 3
    add(1, 1, 32'h0A0B_0C0D, 1, 0,   1, 1, 0, 0, 0, 0, 0, 32'h1234_5678); // c13 ready
    add(1, 1, 32'h0A0B_0C0D, 0, 0,   2, 0, 0, 0, 0, 0, 0, 32'h0A0B_0C0D); // c14 decode
    add(1, 1, 32'h0A0B_0C0D, 0, 0,   3, 0, 1, 0, 0, 0, 0, 32'h0A0B_0C0D); // c15 exec 1
    add(1, 1, 32'h0A0B_0C0D, 0, 0,   3, 0, 0, 0, 0, 0, 0, 32'h0A0B_0C0D); // c16 exec 2
    add(1, 1, 32'h0A0B_0C0D, 0, 0,   3, 0, 0, 0, 0, 0, 0, 32'h0A0B_0C0D); // c17 exec 3
    add(0, 1, 32'h0A0B_0C0D, 1, 0,   3, 0, 0, 0, 0, 0, 0, 32'h0A0B_0C0D); // c18 done in timeout cycle
    add(0, 1, 32'h0A0B_0C0D, 0, 0,   4, 0, 0, 1, 1, 0, 0, 32'h0A0B_0C0D); // c19 wb, run low -> idle
    add(0, 1, 32'h0A0B_0C0D, 0, 0,   0, 0, 0, 0, 0, 0, 0, 32'h0A0B_0C0D); // c20 idle holds
    add(1, 1, 32'hF800_0000, 0, 0,   0, 0, 0, 0, 0, 0, 0, 32'h0A0B_0C0D); // c21 idle -> fetch
    add(1, 1, 32'hF800_0000, 0, 0,   1, 1, 0, 0, 0, 0, 0, 32'h0A0B_0C0D); // c22 fetch halt opcode
    add(1, 1, 32'hF800_0000, 0, 0,   2, 0, 0, 0, 0, 0, 0, 32'hF800_0000); // c23 decode -> halt
    add(1, 1, 32'hF800_0000, 0, 0,   5, 0, 0, 0, 0, 1, 0, 32'hF800_0000); // c24 halt, run held high
    add(1, 1, 32'hF800_0000, 0, 0,   5, 0, 0, 0, 0, 1, 0, 32'hF800_0000); // c25 still halted
    add(0, 1, 32'hF800_0000, 0, 0,   5, 0, 0, 0, 0, 1, 0, 32'hF800_0000); // c26 run low
    add(1, 1, 32'hF800_0000, 0, 0,   5, 0, 0, 0, 1, 1, 0, 32'hF800_0000); // c27 run edge: retire
    add(1, 1, 32'h0000_0001, 0, 0,   1, 1, 0, 0, 0, 0, 0, 32'hF800_0000); // c28 fetch next
    add(1, 1, 32'h0000_0001, 0, 0,   2, 0, 0, 0, 0, 0, 0, 32'h0000_0001); // c29 decode
    add(1, 1, 32'h0000_0001, 0, 0,   3, 0, 1, 0, 0, 0, 0, 32'h0000_0001); // c30 exec 1
    add(1, 1, 32'h0000_0001, 0, 0,   3, 0, 0, 0, 0, 0, 0, 32'h0000_0001); // c31 exec 2
    add(1, 1, 32'h0000_0001, 0, 0,   3, 0, 0, 0, 0, 0, 0, 32'h0000_0001); // c32 exec 3
    add(1, 1, 32'h0000_0001, 0, 0,   3, 0, 0, 0, 0, 0, 0, 32'h0000_0001); // c33 exec 4, no done
    add(1, 1, 32'h0000_0001, 1, 0,   6, 0, 0, 0, 0, 0, 1, 32'h0000_0001); // c34 error
    add(1, 1, 32'h0000_0001, 1, 0,   6, 0, 0, 0, 0, 0, 1, 32'h0000_0001); // c35 error sticks

    #2;
    check_outputs("reset_held", 3'd0, 0, 0, 0, 0, 0, 0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (vecs[i]) begin
      run = vecs[i].run; imem_ready = vecs[i].rdy; imem_inst = vecs[i].inst;
      ex_done = vecs[i].done; wb_suppress = vecs[i].sup;
      @(negedge clk);
      check_outputs($sformatf("v%0d", i), vecs[i].st, vecs[i].req, vecs[i].exs, vecs[i].we,
                    vecs[i].pce, vecs[i].hlt, vecs[i].err, vecs[i].ir);
      @(posedge clk); #1;
    end

`ifdef SEQ_PERF_CNT_EN
    check("perf retired", retired, 32'd4);
    check("perf stall_cycles", stall_cycles, 32'd10);
`endif

    // Reset is the only way out of ERROR.
    #2 reset = 1'b0;
    #1 check_outputs("err_reset", 3'd0, 0, 0, 0, 0, 0, 0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1; run = 1'b1; imem_ready = 1'b1; imem_inst = 32'h8765_4321; ex_done = 1'b0; wb_suppress = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_outputs("pre_abort", 3'd3, 0, 1, 0, 0, 0, 0, 32'h8765_4321);

    // Asynchronous reset mid-EXECUTE, with ex_done arriving while reset is held.
    #2 reset = 1'b0;
    #1 check_outputs("abort_async", 3'd0, 0, 0, 0, 0, 0, 0, 32'h0);
    ex_done = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("abort rf_write_en", 32'(rf_write_en), 32'd0);
      check("abort pc_enable", 32'(pc_enable), 32'd0);
      check("abort state", 32'(state), 32'd0);
    end
    @(posedge clk); #1;
    run = 1'b0; reset = 1'b1;
    @(negedge clk);
    check_outputs("post_abort", 3'd0, 0, 0, 0, 0, 0, 0, 32'h0);
`ifdef SEQ_PERF_CNT_EN
    check("post_abort retired", retired, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_cntrl.md
Name: seq_cntrl

Overview:
Multi-cycle instruction sequencer that replaces the free-running 2-bit state counter in the CPU top level. It steps each instruction through FETCH, DECODE, EXECUTE and WRITE_BACK using handshakes with instruction memory and the execute unit. It owns the instruction register and generates the pc_cntrl enable and the regbank write enable. It supports halt/resume and an execute-timeout error trap.

Parameters:
WIDTH, 32, instruction/data width; opcode is ir[WIDTH-1:WIDTH-5].
HALT_OPC, 5'h1F, opcode that parks the sequencer in HALT.
EXEC_TIMEOUT, 16, maximum EXECUTE cycles without ex_done before ERROR; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
run  in  1  enable; level-sensitive in IDLE/WRITE_BACK, rising-edge-sensitive in HALT.
imem_req  out  1  fetch request, high throughout FETCH.
imem_ready  in  1  instruction valid on imem_inst this cycle.
imem_inst  in  WIDTH  fetched instruction.
ir  out  WIDTH  latched instruction register.
ex_start  out  1  one-cycle pulse on the first EXECUTE cycle.
ex_done  in  1  execute result valid; single-cycle ALU ties it high.
wb_suppress  in  1  decoder says no register write (e.g. branch).
rf_write_en  out  1  regbank write enable.
pc_enable  out  1  pc_cntrl advance enable.
state  out  3  current state encoding.
halted  out  1  high in HALT.
exec_err  out  1  high in ERROR.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITE_BACK=4, HALT=5, ERROR=6. Encoding 7 is illegal and recovers to IDLE on the next clock.
- Reset (reset=0, asynchronous): state=IDLE, ir=0, exec counter=0, registered run_q=0. All outputs are 0 while reset is held and immediately after release. Reset asserted in any state, including mid-fetch or mid-execute, aborts the instruction with no pc or register side effects.
- IDLE: go to FETCH when run=1, otherwise stay.
- FETCH: imem_req=1. When imem_ready=1, ir<=imem_inst and go to DECODE the same edge. Otherwise wait indefinitely; there is no fetch timeout.
- DECODE: exactly 1 cycle. If ir opcode==HALT_OPC go to HALT, else go to EXECUTE.
- EXECUTE: ex_start=1 only in the first cycle; the exec counter is cleared on entry and increments each cycle. ex_done=1 in any cycle, including the first, goes to WRITE_BACK next edge. If the counter reaches EXEC_TIMEOUT with ex_done=0, go to ERROR. ex_done in the timeout cycle wins, so the instruction completes normally.
- WRITE_BACK: exactly 1 cycle. pc_enable=1; rf_write_en=!wb_suppress. Then go to FETCH if run=1, else IDLE.
- HALT: halted=1, pc_enable=0, rf_write_en=0. On a rising edge of run (run=1 and run_q=0), assert pc_enable for that single cycle and go to FETCH, so the halt instruction is retired and not refetched. A run that stays high does not exit HALT.
- ERROR: exec_err=1 and all other control outputs are 0. Only reset exits ERROR.
- Output timing: rf_write_en, pc_enable, imem_req, halted and exec_err are Moore-decoded from state, apart from the run_q edge term in HALT. ex_start is registered. ir holds its value until the next successful fetch.
- Latency: minimum 4 cycles per instruction (FETCH with ready, DECODE, EXECUTE with done, WRITE_BACK); back-to-back instructions with run held high.

Optional Feature:
SEQ_PERF_CNT_EN.
- Defined: adds outputs retired[31:0] and stall_cycles[31:0], both reset to 0.
  - retired increments on every WRITE_BACK cycle and on every HALT exit.
  - stall_cycles increments on each FETCH cycle with imem_ready=0 and each EXECUTE cycle with ex_done=0.
  - Both counters wrap from 0xFFFFFFFF to 0.
- Undefined: neither port exists and no counter logic is synthesised.

Test Plan:
- Reset then run=1; imem_ready and ex_done tied high; instruction 0x00000000 -> states 1,2,3,4 repeating; pc_enable high 1 cycle in 4; rf_write_en=1.
- imem_ready low for 3 cycles in FETCH -> imem_req held high 3 extra cycles; ir updates only on the ready cycle; stall_cycles=3 (perf on).
- wb_suppress=1 during WRITE_BACK -> rf_write_en=0, pc_enable=1.
- ir=0xF8000000 (HALT_OPC) -> HALT, halted=1, no pc_enable; run held high stays halted; run 0->1 gives a 1-cycle pc_enable, then FETCH.
- EXEC_TIMEOUT=4, ex_done=0 -> ERROR after 4 EXECUTE cycles, exec_err=1 until reset=0; ex_done on cycle 4 instead -> WRITE_BACK.
- reset=0 asserted mid-EXECUTE -> state=0, ir=0, all outputs 0 asynchronously; no rf_write_en pulse.
